arith_req_arbiter: RTL
======================

Name: arith_req_arbiter

Overview:
- Shares one registered signed arithmetic unit (add/sub/mul/div, 1-cycle registered result, Arith_enable-gated) between two requesters.
- Accepts operations over valid/ready handshakes and arbitrates round-robin.
- Sequences the unit's enable and operands, then returns the captured result on a shared, tagged response channel with backpressure.

Parameters:
- WIDTH, 16, operand width; result width is 2*WIDTH+1.

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_fun  in  2  00 add, 01 sub, 10 mul, 11 div
- req0_a  in  WIDTH  signed operand A
- req0_b  in  WIDTH  signed operand B
- req1_valid, req1_ready, req1_fun, req1_a, req1_b  same as requester 0, for requester 1
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  1  requester index that owns the response
- rsp_data  out  2*WIDTH+1  signed result
- rsp_err  out  1  error status (see Optional Feature)
- alu_a, alu_b  out  WIDTH  operands to arithmetic unit
- alu_fun  out  2  function select to arithmetic unit
- alu_enable  out  1  arithmetic enable
- alu_out  in  2*WIDTH+1  registered result from arithmetic unit
- alu_flag  in  1  registered valid flag from arithmetic unit

Behaviour:
- FSM states:
  - IDLE: ready to accept; no operation in flight.
  - ISSUE: alu_enable=1 for exactly one cycle.
  - WAIT: arithmetic unit registers the result.
  - RESP: rsp_valid=1 until the response is taken.
- Reset (rst=1 at clk edge), from any state including mid-operation:
  - state=IDLE; rsp_valid, rsp_id, rsp_data, rsp_err, alu_enable, alu_a, alu_b, alu_fun all 0.
  - RR pointer set so requester 0 wins the first tie.
  - Any in-flight operation is discarded; no response is produced for it.
- IDLE:
  - Grant is combinational: one valid requester is granted; if both are valid, the one not granted last wins.
  - reqN_ready=1 only in IDLE and only for the granted requester; ready never depends on rsp_ready.
  - On accept edge: capture fun/a/b into alu_fun/alu_a/alu_b, latch id, update RR pointer, go to ISSUE.
- ISSUE: alu_enable=1 for one cycle; go to WAIT.
- WAIT:
  - alu_enable=0.
  - At the clock edge ending WAIT (arithmetic unit output now registered), capture rsp_data<=alu_out, rsp_err<=~alu_flag, rsp_id<=latched id, rsp_valid<=1; go to RESP.
- RESP:
  - rsp_valid, rsp_id, rsp_data and rsp_err are held stable while rsp_ready=0.
  - On rsp_valid&&rsp_ready: rsp_valid<=0, go to IDLE.
  - No new request is accepted in the same cycle.
- Timing:
  - Latency: accept edge at cycle 0, rsp_valid high from cycle 3.
  - Maximum throughput: one operation per 4 cycles.
- Operand hold: alu_a/alu_b/alu_fun hold the last captured values outside ISSUE; alu_enable=0 in every state except ISSUE.
- Arithmetic: arbiter passes operands unmodified; signedness and width growth are the arithmetic unit's; rsp_data is the full 2*WIDTH+1 value.
- Unselected requester: stalls (ready=0) with no loss; its valid/operands must stay stable until accepted.

Optional Feature:
- Macro: ARITH_ARB_DIVZERO_CHK_EN.
- Defined:
  - At accept of fun=11 with b==0, skip ISSUE/WAIT: go directly to RESP on the next cycle with rsp_data=0 and rsp_err=1.
  - alu_enable stays 0 for that operation.
  - RR pointer still updates.
- Undefined:
  - Divide-by-zero is issued like any other operation; rsp_data is whatever the arithmetic unit produces.
  - rsp_err is ~alu_flag only (normally 0).

Test Plan:
- req0 add a=5, b=-3, rsp_ready=1 -> req0_ready high 1 cycle; alu_enable one pulse; rsp_valid at cycle 3, rsp_id=0, rsp_data=2, rsp_err=0.
- req0 and req1 valid continuously, all subs with a=10, b=4 -> grants alternate 0,1,0,1 starting with 0; every rsp_data=6; ids alternate.
- req1 mul a=-300, b=200 -> rsp_data=-60000 sign-extended to 33 bits; rsp_id=1.
- After div a=-100, b=7, hold rsp_ready=0 for 5 cycles -> rsp_valid, rsp_data=-14, rsp_id stable; both req_ready=0; accept on release, IDLE next.
- Assert rst in WAIT mid-operation -> next cycle all outputs 0, no response for that op; next request serviced with requester 0 winning a tie.
- With ARITH_ARB_DIVZERO_CHK_EN: div a=9, b=0 -> alu_enable never asserted; rsp_valid 1 cycle after accept with rsp_data=0, rsp_err=1.

Source files
------------

// File: rtl/arith_req_arbiter.sv
// ---------------------------------------------------------------------------
// arith_req_arbiter
//
// Shares one registered signed arithmetic unit (add/sub/mul/div) between two
// requesters. Operations arrive on valid/ready handshakes and are granted
// round-robin. The arbiter drives the unit's operands, function and a single
// cycle enable pulse. It then returns the registered result on a shared,
// tagged response channel that supports backpressure.
//
// Ports
//   clk_i, rst_i           clock, synchronous active-high reset
//   reqN_valid_i/ready_o   request handshake for requester N (N = 0, 1)
//   reqN_fun_i             00 add, 01 sub, 10 mul, 11 div
//   reqN_a_i, reqN_b_i     signed operands
//   rsp_valid_o/ready_i    response handshake
//   rsp_id_o               requester index owning the response
//   rsp_data_o             signed result, 2*WIDTH+1 bits
//   rsp_err_o              error status (~alu_flag_i, or divide-by-zero trap)
//   alu_a_o, alu_b_o       operands to the arithmetic unit
//   alu_fun_o              function select to the arithmetic unit
//   alu_enable_o           one-cycle enable to the arithmetic unit
//   alu_out_i, alu_flag_i  registered result / valid flag from the unit
//
// Optional feature, macro ARITH_ARB_DIVZERO_CHK_EN:
//   A divide with b == 0 is not issued to the unit. The arbiter answers it
//   directly on the next cycle with rsp_data = 0 and rsp_err = 1.
//
// States
//   IDLE  | ready to accept, nothing in flight
//   ISSUE | alu_enable_o high for exactly one cycle
//   WAIT  | arithmetic unit registers the result
//   RESP  | response held until rsp_ready_i
// ---------------------------------------------------------------------------
module arith_req_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               req0_valid_i,
    output logic               req0_ready_o,
    input  logic [1:0]         req0_fun_i,
    input  logic [WIDTH-1:0]   req0_a_i,
    input  logic [WIDTH-1:0]   req0_b_i,
    input  logic               req1_valid_i,
    output logic               req1_ready_o,
    input  logic [1:0]         req1_fun_i,
    input  logic [WIDTH-1:0]   req1_a_i,
    input  logic [WIDTH-1:0]   req1_b_i,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic               rsp_id_o,
    output logic [2*WIDTH:0]   rsp_data_o,
    output logic               rsp_err_o,
    output logic [WIDTH-1:0]   alu_a_o,
    output logic [WIDTH-1:0]   alu_b_o,
    output logic [1:0]         alu_fun_o,
    output logic               alu_enable_o,
    input  logic [2*WIDTH:0]   alu_out_i,
    input  logic               alu_flag_i
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               last_q;      // requester granted most recently
    logic               id_q;        // owner of the operation in flight
    logic [2*WIDTH:0]   rsp_data_q;
    logic               rsp_err_q;
    logic               rsp_id_q;
    logic [WIDTH-1:0]   alu_a_q, alu_b_q;
    logic [1:0]         alu_fun_q;

    logic               gnt_vld;
    logic               gnt_id;
    logic [1:0]         sel_fun;
    logic [WIDTH-1:0]   sel_a, sel_b;
    logic               accept;
    logic               div0;

    // Round-robin grant: on a tie the requester not granted last wins.
    always_comb begin
        gnt_vld = req0_valid_i | req1_valid_i;
        gnt_id  = 1'b0;
        if (req0_valid_i && req1_valid_i) begin
            gnt_id = ~last_q;
        end else if (req1_valid_i) begin
            gnt_id = 1'b1;
        end
    end

    assign sel_fun = gnt_id ? req1_fun_i : req0_fun_i;
    assign sel_a   = gnt_id ? req1_a_i   : req0_a_i;
    assign sel_b   = gnt_id ? req1_b_i   : req0_b_i;
    assign accept  = (state_q == S_IDLE) && gnt_vld;

`ifdef ARITH_ARB_DIVZERO_CHK_EN
    assign div0 = (sel_fun == 2'b11) && (sel_b == '0);
`else
    assign div0 = 1'b0;
`endif

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (gnt_vld) begin
                    state_d = div0 ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  state_d = S_RESP;
            S_RESP: begin
                if (rsp_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state; ready never looks at rsp_ready_i
    always_comb begin
        req0_ready_o = accept && !gnt_id;
        req1_ready_o = accept &&  gnt_id;
        alu_enable_o = (state_q == S_ISSUE);
        rsp_valid_o  = (state_q == S_RESP);
    end

    // Datapath: operand capture, RR pointer and response registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q     <= 1'b1;      // requester 0 wins the first tie
            id_q       <= 1'b0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_fun_q  <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            rsp_id_q   <= 1'b0;
        end else begin
            if (accept) begin
                alu_a_q   <= sel_a;
                alu_b_q   <= sel_b;
                alu_fun_q <= sel_fun;
                id_q      <= gnt_id;
                last_q    <= gnt_id;
                if (div0) begin
                    rsp_data_q <= '0;
                    rsp_err_q  <= 1'b1;
                    rsp_id_q   <= gnt_id;
                end
            end
            // End of WAIT: the unit's output is registered and can be taken
            if (state_q == S_WAIT) begin
                rsp_data_q <= alu_out_i;
                rsp_err_q  <= ~alu_flag_i;
                rsp_id_q   <= id_q;
            end
        end
    end

    assign alu_a_o    = alu_a_q;
    assign alu_b_o    = alu_b_q;
    assign alu_fun_o  = alu_fun_q;
    assign rsp_data_o = rsp_data_q;
    assign rsp_err_o  = rsp_err_q;
    assign rsp_id_o   = rsp_id_q;

endmodule
